// File: rtl/seg7_pkg.sv
// Shared constants for the HEX display readback path: active-low segment
// patterns (bit 6 = g .. bit 0 = a), decoder FSM states and value width.
package seg7_pkg;

   localparam int VALUE_W = 6;

   localparam logic [6:0] SEG_D0 = 7'b1000000;
   localparam logic [6:0] SEG_D1 = 7'b1111001;
   localparam logic [6:0] SEG_D2 = 7'b0100100;
   localparam logic [6:0] SEG_D3 = 7'b0110000;
   localparam logic [6:0] SEG_D4 = 7'b0011001;
   localparam logic [6:0] SEG_D5 = 7'b0010010;
   localparam logic [6:0] SEG_D6 = 7'b0000010;
   localparam logic [6:0] SEG_D7 = 7'b1111000;
   localparam logic [6:0] SEG_D8 = 7'b0000000;
   localparam logic [6:0] SEG_D9 = 7'b0010000;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ONE   = 7'b1111001;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DECODE = 2'd2
   } state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational lookup of one active-low seven-segment pattern back to a
// decimal digit; o_legal is low for any pattern that is not 0..9.
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_digit,
   output logic       o_legal
);

   // pattern-to-digit lookup
   always_comb begin
      o_digit = 4'd0;
      o_legal = 1'b1;
      case (i_seg)
         SEG_D0:  o_digit = 4'd0;
         SEG_D1:  o_digit = 4'd1;
         SEG_D2:  o_digit = 4'd2;
         SEG_D3:  o_digit = 4'd3;
         SEG_D4:  o_digit = 4'd4;
         SEG_D5:  o_digit = 4'd5;
         SEG_D6:  o_digit = 4'd6;
         SEG_D7:  o_digit = 4'd7;
         SEG_D8:  o_digit = 4'd8;
         SEG_D9:  o_digit = 4'd9;
         default: begin
            o_digit = 4'd0;
            o_legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seven_seg_signed_decoder.sv
// Readback monitor for the HEX1/HEX0 display bus: synchronizes the segment
// patterns, waits for them to settle and decodes them into a signed value.
module seven_seg_signed_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [6:0]         i_hex1_seg,
   input  logic [6:0]         i_hex0_seg,
   output logic [VALUE_W-1:0] o_value,
   output logic               o_neg,
   output logic               o_valid,
   output logic               o_err,
   output logic               o_stable
);

   localparam logic [3:0]  STABLE_CNT = 4'(STABLE_CYCLES);
   localparam logic [13:0] PAT_BLANK  = 14'h3FFF;

   logic [13:0]        r_sync1;
   logic [13:0]        r_cur;
   logic [13:0]        r_prev;
   logic [13:0]        r_committed;
   logic [3:0]         r_cnt;
   state_t             r_state;
   logic [VALUE_W-1:0] r_value;
   logic               r_neg;
   logic               r_valid;
   logic               r_err;
   logic               r_stable;

   state_t             w_state_nxt;
   logic [3:0]         w_cnt_nxt;
   logic [3:0]         w_digit;
   logic               w_digit_legal;
   logic               w_hex1_legal;
   logic               w_is_neg;
   logic               w_legal;
   logic [VALUE_W-1:0] w_tens;
   logic [VALUE_W-1:0] w_mag;
   logic [VALUE_W-1:0] w_value;

   seg7_digit_decode u_digit (
      .i_seg   (r_cur[6:0]),
      .o_digit (w_digit),
      .o_legal (w_digit_legal)
   );

   // next state and settle counter; returning to the committed pattern aborts the settle
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (r_cur != r_committed) begin
               w_cnt_nxt   = 4'd1;
               w_state_nxt = (STABLE_CNT <= 4'd1) ? DECODE : SETTLE;
            end else begin
               w_cnt_nxt   = 4'd0;
               w_state_nxt = IDLE;
            end
         end
         SETTLE: begin
            if (r_cur == r_committed) begin
               w_cnt_nxt   = 4'd0;
               w_state_nxt = IDLE;
            end else begin
               if (r_cur == r_prev) begin
                  w_cnt_nxt = r_cnt + 4'd1;
               end else begin
                  w_cnt_nxt = 4'd1;
               end
               if (w_cnt_nxt >= STABLE_CNT) begin
                  w_state_nxt = DECODE;
               end else begin
                  w_state_nxt = SETTLE;
               end
            end
         end
         DECODE: begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // sign/tens from HEX1 and the signed result; "-0" is rejected
   always_comb begin
      w_tens       = 6'd0;
      w_is_neg     = 1'b0;
      w_hex1_legal = 1'b1;
      case (r_cur[13:7])
         SEG_BLANK: w_tens   = 6'd0;
         SEG_ONE:   w_tens   = 6'd10;
         SEG_MINUS: w_is_neg = 1'b1;
         default:   w_hex1_legal = 1'b0;
      endcase
      w_mag   = {2'b00, w_digit};
      w_legal = w_hex1_legal & w_digit_legal & ~(w_is_neg & (w_digit == 4'd0));
      if (w_is_neg) begin
         w_value = 6'd0 - w_mag;
      end else begin
         w_value = w_tens + w_mag;
      end
   end

   // input synchronizer, FSM state and history registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= PAT_BLANK;
         r_cur   <= PAT_BLANK;
         r_prev  <= PAT_BLANK;
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_sync1 <= {i_hex1_seg, i_hex0_seg};
         r_cur   <= r_sync1;
         r_prev  <= r_cur;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // commit and publish results on the single DECODE cycle
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_committed <= PAT_BLANK;
         r_value     <= 6'd0;
         r_neg       <= 1'b0;
         r_valid     <= 1'b0;
         r_err       <= 1'b0;
         r_stable    <= 1'b0;
      end else begin
         r_valid  <= 1'b0;
         r_stable <= (r_state == IDLE) && (r_cur == r_committed);
         if (r_state == DECODE) begin
            r_committed <= r_cur;
            if (w_legal) begin
               r_value <= w_value;
               r_neg   <= w_is_neg;
               r_valid <= 1'b1;
               r_err   <= 1'b0;
            end else begin
               r_err   <= 1'b1;
            end
         end else begin
            r_committed <= r_committed;
         end
      end
   end

   assign o_value  = r_value;
   assign o_neg    = r_neg;
   assign o_valid  = r_valid;
   assign o_err    = r_err;
   assign o_stable = r_stable;

endmodule

// File: doc/seven_seg_signed_decoder.md
Name: seven_seg_signed_decoder

Overview:
- Readback side of the HEX display bus: samples the active-low segment patterns driven on HEX1 (sign/tens digit) and HEX0 (units digit).
- Waits for the patterns to hold steady, then decodes them back into a signed two's-complement value.
- Used as an on-chip self-check monitor for the adder/subtractor display path; its value output is compared against the arithmetic result.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical synchronized samples required before decoding (legal range 1..15).

Ports:
- clk  in  1  system clock (50 MHz board clock).
- rst_n  in  1  synchronous, active-low reset.
- hex1_seg  in  7  HEX1 pattern, active-low; bit 0 = segment a … bit 6 = segment g.
- hex0_seg  in  7  HEX0 pattern, same encoding.
- value  out  6  decoded signed value, range -9..+19, two's complement.
- neg  out  1  decoded sign; 1 when HEX1 shows minus.
- valid  out  1  one-cycle pulse when value/neg are updated.
- err  out  1  illegal pattern detected; sticky until next legal decode.
- stable  out  1  level; high while the committed pattern equals the current synchronized input.

Behaviour:
- Reset (rst_n low at a clk edge):
  - value=0, neg=0, valid=0, err=0, stable=0.
  - Sync registers = 7'h7F (blank), committed pattern = 14'h3FFF, counter=0, state=IDLE.
- Input path:
  - Two-flop synchronizer per bit on {hex1_seg, hex0_seg}.
  - All decisions use the second stage (cur).
  - prev holds last cycle's cur.
- FSM, IDLE:
  - If cur != committed: go to SETTLE with cnt=1.
  - Else stay in IDLE.
  - First pattern after reset always differs from 14'h3FFF unless the display is fully blank.
- FSM, SETTLE:
  - If cur == prev: cnt++.
  - Else cnt=1, restart.
  - When cnt reaches STABLE_CYCLES: go to DECODE.
- FSM, DECODE (one cycle):
  - committed <= cur.
  - Legal decode: update value/neg, valid=1, err=0.
  - Illegal decode: value/neg unchanged, valid=0, err=1.
  - Next state: IDLE.
- stable is high in IDLE when cur == committed; low otherwise.
- HEX0 legal patterns (g..a), digits 0..9:
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
- HEX1 legal patterns:
  - blank 1111111 → tens=0, positive.
  - "1" 1111001 → tens=10, positive.
  - minus 0111111 → negative.
- Value rules:
  - Positive: value = tens + digit.
  - Negative: value = -digit.
  - "-0" (minus with digit 0) is illegal.
  - Any other HEX1 or HEX0 pattern is illegal.
- Arithmetic: compute in 6-bit signed; no overflow is possible within -9..+19.
- Latency: if an input change is held, valid pulses exactly STABLE_CYCLES+2 clocks after the first edge that samples the new pattern (6 at default).
- Identical re-presentation of the committed pattern produces no pulse.
- Input glitch shorter than STABLE_CYCLES: no decode, no valid, committed unchanged. If the input returns to the committed pattern, the FSM returns to IDLE at the next compare with no decode.
- Reset mid-SETTLE or in DECODE: all state returns to reset values on that edge; no valid is issued.
- valid and err are never high in the same cycle.

Decomposition:
- Shared package seg7_pkg holds:
  - the ten HEX0 digit pattern constants;
  - SEG_BLANK, SEG_ONE, SEG_MINUS;
  - the state enum (IDLE, SETTLE, DECODE);
  - the value width constant (6).
- One combinational sub-module, seg7_digit_decode: 7-bit pattern → 4-bit digit + legal flag.
- The sign/tens logic stays inline in the top module.

Test Plan:
- Reset then hex1=1111111, hex0=0010010 held → valid pulse 6 clocks later, value=5, neg=0, err=0.
- hex1=1111001, hex0=0000000 held → value=18 (6'b010010), neg=0, single valid pulse, stable high afterwards.
- hex1=0111111, hex0=0011001 held → value=-4 (6'b111100), neg=1; then hex0=1000000 ("-0") → err=1, value stays -4, no valid.
- Glitch: from committed 5, hex0 changes to digit 7 for 3 clocks, then back to 5 → no valid, value stays 5, err unchanged.
- Illegal hex0=1010101 held → err=1 after 6 clocks; then legal "3" (hex1 blank) → valid, value=3, err cleared in the same cycle.
- Assert rst_n=0 for 1 clock at cnt=3 during SETTLE → next cycle value=0, valid=0, err=0, stable=0; the held pattern decodes 6 clocks after reset release.
